// File: rtl/lake_port_harness_if.sv
// ============================================================================
// Module      : lake_port_harness_if
// Description : Stream bundle between the port harness and the lakespec array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lake_port_harness_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_IN     = 2,
    parameter int NUM_OUT    = 2
);
    logic                          flush;
    logic [NUM_IN*DATA_WIDTH-1:0]  w_data;
    logic [NUM_IN-1:0]             w_valid;
    logic [NUM_IN-1:0]             w_ready;
    logic [NUM_OUT*DATA_WIDTH-1:0] r_data;
    logic [NUM_OUT-1:0]            r_valid;
    logic [NUM_OUT-1:0]            r_ready;

    modport master (
        output flush, w_data, w_valid, r_ready,
        input  w_ready, r_data, r_valid
    );

    modport slave (
        input  flush, w_data, w_valid, r_ready,
        output w_ready, r_data, r_valid
    );
endinterface

`default_nettype wire

// File: rtl/lake_port_harness.sv
// ============================================================================
// Module      : lake_port_harness
// Description : Flush/settle/run sequencer driving ramp write streams and
//               capturing read streams into per-port readback buffers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lake_port_harness #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_IN     = 2,
    parameter int NUM_OUT    = 2,
    parameter int CAP_DEPTH  = 1024,
    parameter int CNT_WIDTH  = 32,
    localparam int C_AW      = $clog2(CAP_DEPTH),
    localparam int C_SEL_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    input  wire logic                         start,
    input  wire logic [7:0]                   flush_len,
    input  wire logic [CNT_WIDTH-1:0]         run_len,
    input  wire logic [DATA_WIDTH-1:0]        stride,
    input  wire logic                         adv_mode,
    lake_port_harness_if.master               bus,
    input  wire logic [C_SEL_W-1:0]           rd_sel,
    input  wire logic [C_AW-1:0]              rd_addr,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic [NUM_OUT*(C_AW+1)-1:0]       cap_count,
    output logic [NUM_OUT-1:0]                cap_ovf,
    output logic [CNT_WIDTH-1:0]              cycle_count,
    output logic                              busy,
    output logic                              done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLUSH  = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [7:0]                  r_flush_cnt;
    logic                        r_settle_2nd;
    logic [CNT_WIDTH-1:0]        r_run_len;
    logic [DATA_WIDTH-1:0]       r_stride;
    logic                        r_adv_mode;
    logic                        r_flush;
    logic [NUM_IN-1:0]           r_w_valid;
    logic [NUM_OUT-1:0]          r_r_ready;
    logic [CNT_WIDTH-1:0]        r_cycle_count;
    logic [DATA_WIDTH-1:0]       r_rd_data;
    logic [NUM_IN*DATA_WIDTH-1:0] w_w_data;
    logic [DATA_WIDTH-1:0]       w_rd_words [NUM_OUT];
    logic                        w_start_acc;
    logic                        w_last_run;

    assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last_run  = ((r_cycle_count + CNT_WIDTH'(1)) == r_run_len);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_state_next = (flush_len != 8'd0) ? S_FLUSH : S_SETTLE;
            S_FLUSH:        if (r_flush_cnt == 8'd1) w_state_next = S_SETTLE;
            S_SETTLE:       if (r_settle_2nd) w_state_next = (r_run_len == '0) ? S_DONE : S_RUN;
            S_RUN:          if (w_last_run) w_state_next = S_DONE;
            default:        w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_flush_cnt   <= 8'd0;
            r_settle_2nd  <= 1'b0;
            r_run_len     <= '0;
            r_stride      <= '0;
            r_adv_mode    <= 1'b0;
            r_flush       <= 1'b0;
            r_w_valid     <= '0;
            r_r_ready     <= '0;
            r_cycle_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_flush      <= (w_state_next == S_FLUSH);
            r_w_valid    <= {NUM_IN{w_state_next == S_RUN}};
            r_r_ready    <= {NUM_OUT{w_state_next == S_RUN}};
            r_settle_2nd <= (r_state == S_SETTLE) && !r_settle_2nd;
            if (w_start_acc) begin
                r_flush_cnt   <= flush_len;
                r_run_len     <= run_len;
                r_stride      <= stride;
                r_adv_mode    <= adv_mode;
                r_cycle_count <= '0;
            end else begin
                if (r_state == S_FLUSH) r_flush_cnt <= r_flush_cnt - 8'd1;
                if (r_state == S_RUN)   r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_IN; k++) begin : g_ramp
        logic [DATA_WIDTH-1:0] r_val;
        logic                  w_step;

        assign w_step = (r_state == S_RUN) &&
                        (!r_adv_mode || (r_w_valid[k] && bus.w_ready[k]));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)            r_val <= '0;
            else if (w_start_acc)  r_val <= '0;
            else if (w_step)       r_val <= r_val + r_stride;
        end

        assign w_w_data[k*DATA_WIDTH +: DATA_WIDTH] = r_val;
    end

    for (genvar p = 0; p < NUM_OUT; p++) begin : g_cap
        logic [DATA_WIDTH-1:0] r_mem [CAP_DEPTH];
        logic [C_AW:0]         r_count;
        logic                  r_ovf;
        logic                  w_beat;
        logic                  w_full;

        assign w_beat = (r_state == S_RUN) && bus.r_valid[p] && r_r_ready[p];
        // The count saturates at CAP_DEPTH, a power of two, so its MSB alone flags full.
        assign w_full = r_count[C_AW];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (w_start_acc) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (w_beat) begin
                if (w_full) r_ovf   <= 1'b1;
                else        r_count <= r_count + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (w_beat && !w_full)
                r_mem[r_count[C_AW-1:0]] <= bus.r_data[p*DATA_WIDTH +: DATA_WIDTH];
        end

        assign w_rd_words[p] = r_mem[rd_addr];
        assign cap_count[p*(C_AW+1) +: C_AW+1] = r_count;
        assign cap_ovf[p] = r_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        r_rd_data <= '0;
        else if (int'(rd_sel) < NUM_OUT)   r_rd_data <= w_rd_words[rd_sel];
        else                               r_rd_data <= '0;
    end

    assign bus.flush   = r_flush;
    assign bus.w_data  = w_w_data;
    assign bus.w_valid = r_w_valid;
    assign bus.r_ready = r_r_ready;
    assign rd_data     = r_rd_data;
    assign cycle_count = r_cycle_count;
    assign busy        = (r_state == S_FLUSH) || (r_state == S_SETTLE) || (r_state == S_RUN);
    assign done        = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_lake_port_harness.sv
// ============================================================================
// Module      : tb_lake_port_harness
// Description : Directed bench: loopback runs, ramp modes, overflow, reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lake_port_harness;

    localparam int DW    = 16;
    localparam int NI    = 2;
    localparam int NO    = 4;
    localparam int DEPTH = 8;
    localparam int CW    = 16;
    localparam int AW    = 3;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b0;
    logic                 start     = 1'b0;
    logic [7:0]           flush_len = 8'd0;
    logic [CW-1:0]        run_len   = '0;
    logic [DW-1:0]        stride    = '0;
    logic                 adv_mode  = 1'b0;
    logic [1:0]           rd_sel    = 2'd0;
    logic [AW-1:0]        rd_addr   = '0;
    logic [DW-1:0]        rd_data;
    logic [NO*(AW+1)-1:0] cap_count;
    logic [NO-1:0]        cap_ovf;
    logic [CW-1:0]        cycle_count;
    logic                 busy;
    logic                 done;

    int errors = 0;
    int checks = 0;
    int n_flush, first_run, done_at, n_run, n_acc;
    logic [DW-1:0] seen [64];

    lake_port_harness_if #(.DATA_WIDTH(DW), .NUM_IN(NI), .NUM_OUT(NO)) bus ();

    lake_port_harness #(
        .DATA_WIDTH (DW),
        .NUM_IN     (NI),
        .NUM_OUT    (NO),
        .CAP_DEPTH  (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .flush_len   (flush_len),
        .run_len     (run_len),
        .stride      (stride),
        .adv_mode    (adv_mode),
        .bus         (bus),
        .rd_sel      (rd_sel),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .cap_count   (cap_count),
        .cap_ovf     (cap_ovf),
        .cycle_count (cycle_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Read ports loop back: p0 = stream0, p1 = stream1, p2 = ~stream0, p3 = stream0 ^ 5A5A.
    assign bus.r_data = {bus.w_data[DW-1:0] ^ 16'h5A5A, ~bus.w_data[DW-1:0],
                         bus.w_data[2*DW-1:DW], bus.w_data[DW-1:0]};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_rd(input string tag, input int sel, input int addr, input logic [DW-1:0] exp);
        @(negedge clk);
        rd_sel  = 2'(sel);
        rd_addr = AW'(addr);
        @(negedge clk);
        check(tag, rd_data, exp);
    endtask

    task automatic do_run(input logic [7:0] fl, input logic [CW-1:0] rl, input logic [DW-1:0] st,
                          input logic adv, input logic toggle, input int start_at);
        bit fin;
        fin = 1'b0;
        flush_len = fl; run_len = rl; stride = st; adv_mode = adv;
        n_flush = 0; first_run = -1; done_at = -1; n_run = 0; n_acc = 0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 200 && !fin; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.flush) n_flush++;
            if (bus.w_valid[0]) begin
                if (first_run < 0) first_run = n;
                bus.w_ready[0] = toggle ? (n_run % 2 == 0) : 1'b1;
                if (n_run < 64) seen[n_run] = bus.w_data[DW-1:0];
                if (bus.w_ready[0]) n_acc++;
                if (n_run == start_at) start = 1'b1;
                n_run++;
            end
            if (done) begin
                done_at = n;
                fin = 1'b1;
            end
        end
        start = 1'b0;
        bus.w_ready[0] = 1'b1;
        check("run_terminates", 64'(fin), 64'd1);
    endtask

    initial begin
        bus.w_ready = 2'b11;
        bus.r_valid = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_flush",   bus.flush,   0);
        check("rst_w_valid", bus.w_valid, 0);
        check("rst_r_ready", bus.r_ready, 0);
        check("rst_w_data",  bus.w_data,  0);
        check("rst_misc",    {rd_data, cap_count, cap_ovf, cycle_count, busy, done}, 0);
        rst_n = 1'b1;

        // Plain ramp, stride 2, all ports capture 8 beats exactly filling the buffers
        do_run(8'd4, 16'd8, 16'd2, 1'b0, 1'b0, -1);
        check("a_flush_cycles", n_flush, 4);
        check("a_first_run",    first_run, 7);
        check("a_done_at",      done_at, 15);
        check("a_run_cycles",   n_run, 8);
        for (int i = 0; i < 8; i++) check($sformatf("a_wdata%0d", i), seen[i], 2 * i);
        check("a_cycle_count",  cycle_count, 8);
        check("a_cap_count",    cap_count, 16'h8888);
        check("a_cap_ovf",      cap_ovf, 0);
        check("a_busy",         busy, 0);
        check_rd("a_rd_p0_a5", 0, 5, 16'd10);
        check_rd("a_rd_p1_a7", 1, 7, 16'd14);
        check_rd("a_rd_p2_a3", 2, 3, 16'hFFF9);
        check_rd("a_rd_p3_a5", 3, 5, 16'h5A50);

        // Per-beat advance with stream0 ready toggling; start pulse mid-run is ignored
        do_run(8'd1, 16'd8, 16'd3, 1'b1, 1'b1, 3);
        check("b_first_run",  first_run, 4);
        check("b_done_at",    done_at, 12);
        check("b_seq",        {seen[0], seen[1], seen[2], seen[3], seen[4], seen[5], seen[6], seen[7]},
                              {16'd0, 16'd3, 16'd3, 16'd6, 16'd6, 16'd9, 16'd9, 16'd12});
        check("b_accepted",   n_acc, 4);
        check("b_cycle_count", cycle_count, 8);
        check_rd("b_rd_p0_a2", 0, 2, 16'd3);
        check_rd("b_rd_p1_a5", 1, 5, 16'd15);

        // Overflow on ports 0 and 2 only; ports 1 and 3 keep prior RAM contents
        bus.r_valid = 4'b0101;
        do_run(8'd2, 16'd10, 16'd1, 1'b0, 1'b0, -1);
        check("c_done_at",     done_at, 15);
        check("c_cycle_count", cycle_count, 10);
        check("c_cap_count",   cap_count, 16'h0808);
        check("c_cap_ovf",     cap_ovf, 4'b0101);
        check_rd("c_rd_p0_a7", 0, 7, 16'd7);
        check_rd("c_rd_p2_a0", 2, 0, 16'hFFFF);
        check_rd("c_rd_p1_a2", 1, 2, 16'd6);
        bus.r_valid = 4'hF;

        // Zero flush and zero run length
        do_run(8'd0, 16'd0, 16'd2, 1'b0, 1'b0, -1);
        check("d_flush_cycles", n_flush, 0);
        check("d_run_cycles",   n_run, 0);
        check("d_done_at",      done_at, 3);
        check("d_counts",       {cap_count, cap_ovf, cycle_count}, 0);

        // Asynchronous reset in the middle of RUN
        flush_len = 8'd0; run_len = 16'd20; stride = 16'd1; adv_mode = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.w_valid[0] && bus.w_data[DW-1:0] == 16'd3) break;
        end
        check("e_reached_run3", bus.w_data[DW-1:0], 16'd3);
        #2 rst_n = 1'b0;
        #1;
        check("e_rst_bus",  {bus.flush, bus.w_valid, bus.r_ready, bus.w_data}, 0);
        check("e_rst_misc", {rd_data, cap_count, cap_ovf, cycle_count, busy, done}, 0);
        @(negedge clk); rst_n = 1'b1;
        do_run(8'd1, 16'd4, 16'd5, 1'b0, 1'b0, -1);
        check("e_done_at",     done_at, 8);
        check("e_seq",         {seen[0], seen[1], seen[2], seen[3]}, {16'd0, 16'd5, 16'd10, 16'd15});
        check("e_cycle_count", cycle_count, 4);
        check("e_cap_count",   cap_count, 16'h4444);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lake_port_harness.md
# lake_port_harness

Parametrised, synthesizable stimulus/capture harness for the lakespec port array, replacing the fixed 2/4/8-port simulation sequencer. It sequences flush, drives NUM_IN write streams with a programmable ramp under valid/ready, and captures NUM_OUT read streams into per-port buffers readable after the run. It sits between a host/config interface and lakespec for FPGA emulation and for regression benches.

## Interface
- DATA_WIDTH, 16, stream word width
- NUM_IN, 2, write streams driven into the DUT (1..4)
- NUM_OUT, 2, read streams captured from the DUT (1..4)
- CAP_DEPTH, 1024, words per capture buffer (power of 2); AW = clog2(CAP_DEPTH)
- CNT_WIDTH, 32, run/cycle counter width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled in IDLE/DONE only
- flush_len  in  8  cycles flush is held high
- run_len  in  CNT_WIDTH  number of RUN cycles
- stride  in  DATA_WIDTH  ramp increment (legacy value 2)
- adv_mode  in  1  0: ramp advances every RUN cycle; 1: per-stream ramp advances only on accepted beat
- flush  out  1  DUT flush
- w_data  out  NUM_IN*DATA_WIDTH  write stream data, stream k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- w_valid  out  NUM_IN  write valid
- w_ready  in  NUM_IN  write ready from DUT
- r_data  in  NUM_OUT*DATA_WIDTH  read stream data
- r_valid  in  NUM_OUT  read valid from DUT
- r_ready  out  NUM_OUT  read ready to DUT
- rd_sel  in  clog2(NUM_OUT) (min 1)  capture buffer select
- rd_addr  in  AW  capture buffer address
- rd_data  out  DATA_WIDTH  capture readback, 1-cycle latency
- cap_count  out  NUM_OUT*(AW+1)  words captured per port
- cap_ovf  out  NUM_OUT  sticky: beat arrived with buffer full
- cycle_count  out  CNT_WIDTH  RUN cycles elapsed
- busy  out  1  state is FLUSH, SETTLE or RUN
- done  out  1  state is DONE

## Operation
- FSM: IDLE -> FLUSH -> SETTLE -> RUN -> DONE; DONE -> FLUSH on start.
- IDLE/DONE: start=1 -> FLUSH; start ignored in other states.
- FLUSH: flush=1 for flush_len cycles; flush_len=0 skips straight to SETTLE (flush never asserts).
- SETTLE: exactly 2 cycles, flush=0, w_valid=0, r_ready=0.
- RUN: run_len cycles; w_valid all-ones, r_ready all-ones; run_len=0 -> DONE after SETTLE with no RUN cycles.
- On FLUSH entry: cycle_count, cap_count, cap_ovf, ramp values cleared to 0. Inputs flush_len/run_len/stride/adv_mode latched at start.
- Ramp, adv_mode=0: every stream drives cycle_count*stride (common value), modulo 2^DATA_WIDTH.
- Ramp, adv_mode=1: stream k holds its value until w_valid[k]&w_ready[k], then adds stride; streams independent.
- Capture: in RUN, r_valid[p]&r_ready[p] writes r_data[p] at cap_count[p], increments it; at cap_count=CAP_DEPTH write dropped, cap_ovf[p] set, count saturates.
- Beats outside RUN are never captured.
- rd_data = buffer[rd_sel][rd_addr] registered; rd_sel >= NUM_OUT returns 0. Readback legal in any state.
- Capture RAM contents are not reset; only counters/flags are.
- Reset mid-operation: immediate return to IDLE, all outputs to reset values, partial run discarded.

## Timing
- Reset values: flush=0, w_data=0, w_valid=0, r_ready=0, rd_data=0, cap_count=0, cap_ovf=0, cycle_count=0, busy=0, done=0.
- All outputs registered except busy/done (decoded from state register).
- start high at edge t -> flush=1 during cycles t+1..t+flush_len; first RUN cycle t+flush_len+3; done=1 from cycle after last RUN cycle, held until next start.
- cycle_count increments at end of each RUN cycle; equals run_len when done=1.
- adv_mode=0 beat value in RUN cycle i (0-based) is i*stride regardless of w_ready.
- Capture write and cap_count increment same edge; new count visible next cycle.

## Test plan
- NUM_IN=NUM_OUT=1, flush_len=4, run_len=8, stride=2, adv_mode=0, loopback w->r with ready=1 -> flush high 4 cycles, captured 0,2,4..14, cap_count=8, cycle_count=8, done=1.
- adv_mode=1, stride=3, w_ready toggling 1,0,1,0 over 8 RUN cycles -> w_data sequence 0,3,3,6,6,9,9,12; 4 accepted beats.
- CAP_DEPTH=4, run_len=6, r_valid=1 -> cap_count=4, cap_ovf=1, buffer holds first 4 words.
- flush_len=0, run_len=0 -> flush never asserts, done 3 cycles after start, cap_count=0.
- rst_n low mid-RUN (cycle 3) -> all outputs to reset values asynchronously, state IDLE; new start runs cleanly from 0.
- NUM_OUT=4, distinct patterns per port, readback each rd_sel/rd_addr -> correct word 1 cycle later; rd_sel=4 on NUM_OUT=4... not used; start asserted during RUN -> ignored, run completes unchanged.
